// File: rtl/narnet_step_scheduler.sv
// narnet_step_scheduler: steps the NARNet core one prediction at a time, in open or closed loop
// Ports: clk, rst_n (async active-low); enable freezes all state; mode/start/horizon launch runs;
// s_* is the sample input FIFO port; core_* drives and observes the core;
// m_* is the prediction output port; busy and timeout_err report status.
module narnet_step_scheduler #(
   parameter int DATA_W = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT = 255,
   parameter logic [DATA_W-1:0] Y_INIT = 8'h18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              mode,
   input  logic              start,
   input  logic [7:0]        horizon,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              core_enable,
   output logic              core_rst,
   output logic              core_x_ready,
   output logic [DATA_W-1:0] core_x_in,
   input  logic [DATA_W-1:0] core_y_out,
   input  logic              core_out_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic              timeout_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0] PTR_ONE = 1;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, RECOVER} state_t;
   state_t state_q, state_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic [DATA_W-1:0] x_q, x_d, y_last_q, y_last_d, m_data_q, m_data_d;
   logic [7:0] steps_q, steps_d;
   logic [WW-1:0] wd_q, wd_d;
   logic run_q, run_d, m_valid_q, m_valid_d, m_last_q, m_last_d, err_q, err_d;
   logic empty, full, push, pop;
   assign empty = wr_q == rd_q;
   // extra pointer bit distinguishes full from empty when the indices match
   assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign push = enable && s_valid && !full;
   // empty comes from registered pointers, so a same-cycle push is never popped
   assign pop = enable && state_q == IDLE && !mode && !empty;
   always_comb begin
      state_d = state_q;
      mem_d = mem_q;
      wr_d = wr_q;
      rd_d = rd_q;
      x_d = x_q;
      y_last_d = y_last_q;
      m_data_d = m_data_q;
      steps_d = steps_q;
      wd_d = wd_q;
      run_d = run_q;
      m_valid_d = m_valid_q;
      m_last_d = m_last_q;
      err_d = err_q;
      if (push) begin
         mem_d[wr_q[AW-1:0]] = s_data;
         wr_d = wr_q + PTR_ONE;
      end
      if (pop) rd_d = rd_q + PTR_ONE;
      if (enable) begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  x_d = mem_q[rd_q[AW-1:0]];
                  run_d = 1'b0;
                  state_d = ISSUE;
               end else if (mode && start && horizon != 8'd0) begin
                  x_d = y_last_q;
                  steps_d = horizon;
                  run_d = 1'b1;
                  state_d = ISSUE;
               end
            end
            ISSUE: begin
               // the pulse cycle counts as the first watchdog cycle
               wd_d = WW'(1);
               state_d = WAIT;
            end
            WAIT: begin
               if (core_out_ready) begin
                  y_last_d = core_y_out;
                  m_data_d = core_y_out;
                  m_valid_d = 1'b1;
                  m_last_d = run_q && steps_q == 8'd1;
                  state_d = EMIT;
               end else if (wd_q == WW'(TIMEOUT - 1)) begin
                  err_d = 1'b1;
                  state_d = RECOVER;
               end else begin
                  wd_d = wd_q + WW'(1);
               end
            end
            EMIT: begin
               if (m_ready) begin
                  m_valid_d = 1'b0;
                  m_last_d = 1'b0;
                  if (run_q && steps_q > 8'd1) begin
                     steps_d = steps_q - 8'd1;
                     x_d = y_last_q;
                     state_d = ISSUE;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mem_q <= '{default: '0};
         wr_q <= '0;
         rd_q <= '0;
         x_q <= '0;
         y_last_q <= Y_INIT;
         m_data_q <= '0;
         steps_q <= '0;
         wd_q <= '0;
         run_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mem_q <= mem_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         x_q <= x_d;
         y_last_q <= y_last_d;
         m_data_q <= m_data_d;
         steps_q <= steps_d;
         wd_q <= wd_d;
         run_q <= run_d;
         m_valid_q <= m_valid_d;
         m_last_q <= m_last_d;
         err_q <= err_d;
      end
   end
   assign s_ready = !full;
   assign core_enable = enable && rst_n;
   assign core_x_ready = enable && state_q == ISSUE;
   assign core_rst = enable && state_q == RECOVER;
   assign core_x_in = x_q;
   assign m_valid = m_valid_q;
   assign m_data = m_data_q;
   assign m_last = m_last_q;
   assign busy = state_q != IDLE;
   assign timeout_err = err_q;
endmodule

// File: tb/tb_narnet_step_scheduler.sv
// tb_narnet_step_scheduler: directed self-checking bench with a behavioural core model
module tb_narnet_step_scheduler;
   localparam int TIMEOUT = 255;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, mode = 1'b0, start = 1'b0;
   logic s_valid = 1'b0, m_ready = 1'b1, core_out_ready = 1'b0;
   logic [7:0] horizon = 8'd0, s_data = 8'd0, core_y_out = 8'd0;
   logic s_ready, core_enable, core_rst, core_x_ready, m_valid, m_last, busy, timeout_err;
   logic [7:0] core_x_in, m_data;
   int n_chk = 0, n_pass = 0, n_rst = 0, core_lat = 5, bad;
   logic [7:0] core_add = 8'd1;
   logic core_hang = 1'b0;
   logic [7:0] px [$];

   narnet_step_scheduler #(.DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT), .Y_INIT(8'h18)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .start(start), .horizon(horizon),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .core_enable(core_enable),
      .core_rst(core_rst), .core_x_ready(core_x_ready), .core_x_in(core_x_in),
      .core_y_out(core_y_out), .core_out_ready(core_out_ready), .m_valid(m_valid),
      .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic push(input logic [7:0] d);
      s_valid = 1'b1;
      s_data = d;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic get_out(input string tag, input logic [7:0] d, input logic l);
      int k = 0;
      while (!m_valid && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_valid"}, m_valid, 1);
      chk({tag, "_data"}, m_data, d);
      chk({tag, "_last"}, m_last, l);
      @(negedge clk);
   endtask

   task automatic wait_pulse(input string tag);
      int k = 0;
      while (!core_x_ready && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk(tag, core_x_ready, 1);
   endtask

   initial begin : core_model
      logic [7:0] cx;
      forever begin
         @(negedge clk);
         if (core_x_ready && !core_hang) begin
            cx = core_x_in;
            repeat (core_lat - 1) @(negedge clk);
            core_y_out = cx + core_add;
            core_out_ready = 1'b1;
            @(negedge clk);
            core_out_ready = 1'b0;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (core_x_ready) px.push_back(core_x_in);
         if (core_rst) n_rst++;
      end
   end

   initial begin : guard
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_x_ready", core_x_ready, 0);
      chk("rst_core_rst", core_rst, 0);
      chk("rst_x_in", core_x_in, 0);
      chk("rst_core_en", core_enable, 0);
      chk("rst_err", timeout_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("core_en", core_enable, 1);
      // closed-loop launch filters
      mode = 1'b1; horizon = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("h0_ignored", busy, 0);
      mode = 1'b0; horizon = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("mode0_start_ignored", busy, 0);
      // closed-loop run of 3 with y = x + 1; inputs changed mid-run must not matter
      px.delete();
      mode = 1'b1; horizon = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mode = 1'b0; horizon = 8'd0;
      get_out("cl1", 8'h19, 0);
      get_out("cl2", 8'h1a, 0);
      chk("cl_busy_mid", busy, 1);
      get_out("cl3", 8'h1b, 1);
      chk("cl_busy_end", busy, 0);
      chk("cl_npulse", px.size(), 3);
      chk("cl_x0", px[0], 8'h18);
      chk("cl_x1", px[1], 8'h19);
      chk("cl_x2", px[2], 8'h1a);
      // open-loop with 40-cycle core, y = x + 5
      core_lat = 40; core_add = 8'h05; px.delete();
      push(8'h10);
      push(8'h20);
      get_out("ol1", 8'h15, 0);
      get_out("ol2", 8'h25, 0);
      chk("ol_npulse", px.size(), 2);
      chk("ol_x0", px[0], 8'h10);
      chk("ol_x1", px[1], 8'h20);
      // backpressure
      core_lat = 5; core_add = 8'h01; m_ready = 1'b0;
      push(8'h30);
      push(8'h40);
      begin
         int k = 0;
         while (!m_valid && k < 100) begin @(negedge clk); k++; end
      end
      chk("bp_valid", m_valid, 1);
      px.delete();
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!m_valid || m_data !== 8'h31 || core_x_ready) bad++;
      end
      chk("bp_stable", bad, 0);
      chk("bp_no_pulse", px.size(), 0);
      m_ready = 1'b1;
      get_out("bp1", 8'h31, 0);
      get_out("bp2", 8'h41, 0);
      // FIFO full while the scheduler is held in EMIT
      m_ready = 1'b0; px.delete();
      push(8'h50);
      repeat (10) @(negedge clk);
      chk("ff_busy", busy, 1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ff_ready%0d", i), s_ready, 1);
         push(8'h51 + 8'(i));
      end
      chk("ff_full", s_ready, 0);
      s_valid = 1'b1; s_data = 8'h5f;
      repeat (3) @(negedge clk);
      chk("ff_refuse", s_ready, 0);
      s_valid = 1'b0; m_ready = 1'b1;
      get_out("ff0", 8'h51, 0);
      begin
         int k = 0;
         while (!s_ready && k < 20) begin @(negedge clk); k++; end
      end
      chk("ff_ready_again", s_ready, 1);
      for (int i = 0; i < 4; i++) get_out($sformatf("ff%0d", i + 1), 8'h52 + 8'(i), 0);
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (m_valid) bad++;
      end
      chk("ff_no_fifth", bad, 0);
      chk("ff_npulse", px.size(), 5);
      chk("ff_x4", px[4], 8'h54);
      // watchdog
      core_hang = 1'b1; n_rst = 0;
      push(8'h70);
      wait_pulse("wd_pulse");
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("wd_err_early", timeout_err, 0);
      chk("wd_rst_early", core_rst, 0);
      @(negedge clk);
      chk("wd_err", timeout_err, 1);
      chk("wd_core_rst", core_rst, 1);
      @(negedge clk);
      chk("wd_core_rst_end", core_rst, 0);
      chk("wd_idle", busy, 0);
      chk("wd_nrst", n_rst, 1);
      chk("wd_no_valid", m_valid, 0);
      core_hang = 1'b0;
      push(8'h71);
      get_out("wd_next", 8'h72, 0);
      chk("wd_sticky", timeout_err, 1);
      // async reset mid-WAIT
      core_lat = 40;
      push(8'h60);
      wait_pulse("ar_pulse");
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_m_valid", m_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_s_ready", s_ready, 1);
      chk("ar_x_ready", core_x_ready, 0);
      chk("ar_err", timeout_err, 0);
      chk("ar_m_data", m_data, 0);
      chk("ar_x_in", core_x_in, 0);
      chk("ar_core_en", core_enable, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (m_valid || busy) bad++;
      end
      chk("ar_late_ignored", bad, 0);
      px.delete();
      mode = 1'b1; horizon = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mode = 1'b0;
      get_out("ar_post", 8'h19, 1);
      chk("ar_post_x", px[0], 8'h18);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
